// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial converter with one-word holding buffer
// Streams WIDTH-bit words onto x_out with zero-gap back-to-back operation.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdy_en_q, rdy_en_d;

  logic             accept;
  logic [WIDTH-1:0] sh_shifted;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  // The output end of sh is the MSB or LSB; shifting moves the next bit there.
  always_comb begin
    if (MSB_FIRST) sh_shifted = {sh_q[WIDTH-2:0], 1'b0};
    else           sh_shifted = {1'b0, sh_q[WIDTH-1:1]};
  end

  assign accept = din_valid & din_ready;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    rdy_en_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d    = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          sh_d  = sh_shifted;
          cnt_d = cnt_q + 1'b1;
          if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end else begin
          cnt_d = '0;
          // Last bit on the wire: chain the next word with no idle cycle.
          if (hold_full_q) begin
            sh_d        = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            sh_d = din;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    din_ready = rdy_en_q & ~hold_full_q;
    x_valid   = (state_q == SHIFT);
    x_out     = 1'b0;
    word_done = 1'b0;
    if (state_q == SHIFT) begin
      x_out     = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
      word_done = (cnt_q == LAST);
    end
  end

endmodule
